// File: rtl/alu_pkg.sv
// Shared definitions for the alu and the multiply sequencer that drives it.
package alu_pkg;

  // alu operation encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_NULL = 4'b1111;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational alu: ADD / SUB / PASS (forwards in1) / NULL (drives zero).
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] out0,
  output logic             zero
);

  // Operation decode; unknown encodings behave as NULL
  always_comb begin
    out0 = '0;
    unique case (aluop)
      ALU_ADD:  out0 = in0 + in1;
      ALU_SUB:  out0 = in0 - in1;
      ALU_PASS: out0 = in1;
      default:  out0 = '0;
    endcase
  end

  // Zero flag for branch logic
  always_comb begin
    zero = (out0 == '0);
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer. Borrows the shared alu for one add (or pass)
// per cycle and stops as soon as the remaining multiplier bits are all zero.
// The result is the low WIDTH bits of the unsigned product.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_zero,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out
);

  mul_state_e       r_state;
  mul_state_e       w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_product;
  logic             r_prod_zero;

  logic             w_accept;
  logic             w_run;
  logic [WIDTH-1:0] w_mplier_shr;
  logic             w_last_iter;

  assign w_accept     = (r_state == StIdle) && start;
  assign w_run        = (r_state == StRun);
  assign w_mplier_shr = r_mplier >> 1;
  // Early exit when no set multiplier bits remain; the count bound caps the
  // run at WIDTH iterations regardless.
  assign w_last_iter  = (w_mplier_shr == '0) || (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (op_b == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_last_iter) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: handshake flags and alu operand/op selection
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    alu_op  = ALU_NULL;
    alu_in0 = '0;
    alu_in1 = '0;
    unique case (r_state)
      StRun: begin
        busy = 1'b1;
        if (r_mplier[0]) begin
          alu_op  = ALU_ADD;
          alu_in0 = r_acc;
          alu_in1 = r_mcand;
        end else begin
          // Keep acc flowing through the alu so the update path is uniform
          alu_op  = ALU_PASS;
          alu_in0 = '0;
          alu_in1 = r_acc;
        end
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Iteration datapath: operand capture on accept, one shift-and-add step per RUN cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_acc    <= alu_out;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Result register: loaded on the edge entering DONE, held until the next one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_product   <= '0;
      r_prod_zero <= 1'b1;
    end else if (w_accept && (op_b == '0)) begin
      r_product   <= '0;
      r_prod_zero <= 1'b1;
    end else if (w_run && w_last_iter) begin
      r_product   <= alu_out;
      r_prod_zero <= (alu_out == '0);
    end
  end

  assign product   = r_product;
  assign prod_zero = r_prod_zero;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq wired to the shared alu.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rstn;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             prod_zero;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  int n_tests;
  int n_fail;

  logic [3:0]       ops_q[$];
  logic [WIDTH-1:0] in0_q[$];
  logic [WIDTH-1:0] in1_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_prod;
    logic             exp_zero;
    int               exp_lat;
  } vec_t;

  vec_t vecs[10];

  alu_mul_seq #(
    .WIDTH(WIDTH),
    .CNT_W(6)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .prod_zero(prod_zero),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .alu_op   (alu_op),
    .alu_out  (alu_out)
  );

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .in0  (alu_in0),
    .in1  (alu_in1),
    .aluop(alu_op),
    .out0 (alu_out),
    .zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one multiply, record RUN-cycle alu activity, return result and latency
  // (number of edges from the accepting edge to the first edge that sees done).
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] prod, output logic pz,
                         output int lat);
    ops_q.delete();
    in0_q.delete();
    in1_q.delete();
    lat  = -1;
    prod = '0;
    pz   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done) begin
        lat  = j;
        prod = product;
        pz   = prod_zero;
        break;
      end
      if (busy) begin
        ops_q.push_back(alu_op);
        in0_q.push_back(alu_in0);
        in1_q.push_back(alu_in1);
      end
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no done within 60 cycles for a=%h b=%h", a, b);
    end
  endtask

  logic [WIDTH-1:0] r_prod;
  logic             r_pz;
  int               r_lat;
  int               wait_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    rstn    = 1'b0;

    vecs[0] = '{32'd3,        32'd5,        32'd15,       1'b0, 4};
    vecs[1] = '{32'd123,      32'd0,        32'd0,        1'b1, 1};
    vecs[2] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0, 33};
    vecs[3] = '{32'd6,        32'd7,        32'd42,       1'b0, 4};
    vecs[4] = '{32'd1,        32'd1,        32'd1,        1'b0, 2};
    vecs[5] = '{32'd0,        32'hFF,       32'd0,        1'b1, 9};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'd0,      1'b1, 18};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,      1'b0, 33};
    vecs[8] = '{32'h1234_5678, 32'd1,       32'h1234_5678, 1'b0, 2};
    vecs[9] = '{32'd5,        32'd8,        32'd40,       1'b0, 5};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_prod_zero", {31'd0, prod_zero}, 32'd1);
    chk("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_NULL});
    @(negedge clk);
    rstn = 1'b1;

    // Basic: ADD, PASS, ADD with operands taken from acc/mcand
    run_mul(32'd3, 32'd5, r_prod, r_pz, r_lat);
    chk("basic_nops", ops_q.size(), 32'd3);
    if (ops_q.size() == 3) begin
      chk("basic_op0", {28'd0, ops_q[0]}, {28'd0, ALU_ADD});
      chk("basic_op1", {28'd0, ops_q[1]}, {28'd0, ALU_PASS});
      chk("basic_op2", {28'd0, ops_q[2]}, {28'd0, ALU_ADD});
      chk("basic_in0_0", in0_q[0], 32'd0);
      chk("basic_in1_0", in1_q[0], 32'd3);
      chk("basic_in1_1", in1_q[1], 32'd3);
      chk("basic_in0_2", in0_q[2], 32'd3);
      chk("basic_in1_2", in1_q[2], 32'd12);
    end
    chk("basic_lat", r_lat, 32'd4);
    chk("basic_prod", r_prod, 32'd15);

    // Zero multiplier: no RUN cycles at all
    run_mul(32'd123, 32'd0, r_prod, r_pz, r_lat);
    chk("zero_nops", ops_q.size(), 32'd0);
    @(negedge clk);
    chk("zero_idle_alu_op", {28'd0, alu_op}, {28'd0, ALU_NULL});
    chk("zero_held_product", product, 32'd0);

    // Table of directed vectors
    for (int i = 0; i < 10; i++) begin
      run_mul(vecs[i].a, vecs[i].b, r_prod, r_pz, r_lat);
      chk($sformatf("vec%0d_prod", i), r_prod, vecs[i].exp_prod);
      chk($sformatf("vec%0d_zero", i), {31'd0, r_pz}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("vec%0d_lat", i), r_lat, vecs[i].exp_lat);
    end

    // Reset mid-run aborts immediately
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_prod_zero", {31'd0, prod_zero}, 32'd1);
    chk("mid_rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_NULL});
    @(negedge clk);
    rstn = 1'b1;
    run_mul(32'd6, 32'd7, r_prod, r_pz, r_lat);
    chk("after_rst_prod", r_prod, 32'd42);
    chk("after_rst_lat", r_lat, 32'd4);

    // Busy-ignore, then a start held across DONE is taken one edge after IDLE
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = 32'd2;
    op_b  = 32'd2;
    wait_cnt = 0;
    while (!done && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("ign_done_seen", {31'd0, done}, 32'd1);
    chk("ign_prod", product, 32'd15);
    @(posedge clk);
    #1;
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_accept_busy", {31'd0, busy}, 32'd1);
    chk("held_prod_kept", product, 32'd15);
    start = 1'b0;
    wait_cnt = 0;
    while (!done && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("held_done_seen", {31'd0, done}, 32'd1);
    chk("held_prod", product, 32'd4);
    chk("held_prod_zero", {31'd0, prod_zero}, 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle sequencer that computes the unsigned product of two WIDTH-bit operands by shift-and-add.
- Drives the shared alu (ops ADD / PASS / NULL) one iteration per cycle.
- Sits between the CPU control unit (start/done handshake) and the alu operand/op muxes.
- Result is the low WIDTH bits of the product, matching RISC-V MUL.
- Terminates early once the remaining multiplier bits are all zero.

Parameters:
WIDTH, 32, operand/product width; must match the alu datapath.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
op_a  input  WIDTH  multiplicand; captured when start is accepted.
op_b  input  WIDTH  multiplier; captured when start is accepted.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; product valid.
product  output  WIDTH  result; held until the next accepted start.
prod_zero  output  1  product == 0; valid with product.
alu_in0  output  WIDTH  to alu in0.
alu_in1  output  WIDTH  to alu in1.
alu_op  output  4  to alu aluop.
alu_out  input  WIDTH  from alu out0.

Behaviour:
- Interface clocking: single clock clk. rstn is asynchronous and active-low.
- Reset: state=IDLE; busy=0, done=0, product=0, prod_zero=1; internal acc/mcand/mplier/cnt=0.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced and the partial result is discarded.
- States:
  - IDLE: start=1 at a clock edge loads acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0. Next state is DONE if op_b==0, else RUN. start=0 stays in IDLE.
  - RUN: one iteration per cycle. Combinationally:
    - mplier[0]==1: alu_op=ADD, alu_in0=acc, alu_in1=mcand.
    - mplier[0]==0: alu_op=PASS, alu_in0=0, alu_in1=acc.
    - At the clock edge: acc<=alu_out; mcand<=mcand<<1 (MSB dropped); mplier<=mplier>>1 (logical); cnt<=cnt+1.
    - Exit to DONE when (mplier>>1)==0 or cnt==WIDTH-1. Otherwise stay in RUN.
  - DONE: held for exactly one cycle. done=1, product=acc, prod_zero=(acc==0). Next state is IDLE unconditionally.
- Outside RUN: alu_op=NULL (4'b1111), alu_in0=0, alu_in1=0.
- Registering: product and prod_zero are registered on the edge entering DONE and held through IDLE until the next accepted start. product is not cleared on start.
- Latency: done asserts n+1 cycles after the accepting edge, where n = index of the highest set bit of op_b, plus 1 (n=0 when op_b==0). Worst case is WIDTH+1 cycles.
- start while busy is ignored; there is no queueing.
- start asserted in the same cycle DONE returns to IDLE is not accepted; it is accepted at the following edge only if still high. Minimum issue interval is therefore n+2 cycles.
- Arithmetic: modulo 2^WIDTH; the alu ADD wraps. No overflow flag is produced.
- alu zero output is unused.

Decomposition:
- Shared package alu_pkg:
  - alu op encodings ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_PASS=4'b0010, ALU_NULL=4'b1111.
  - State encoding for IDLE/RUN/DONE.
- No sub-module inside alu_mul_seq. The alu is instantiated alongside it at the parent level.
- The bench instantiates alu_mul_seq plus the existing alu as the natural verification harness.

Test Plan:
- Reset mid-run: op_a=7, op_b=32'hFFFF_FFFF; assert rstn low at RUN cycle 10 -> all outputs return to reset values asynchronously. After release, a new start 6*7 yields product=42.
- Basic: op_a=3, op_b=5, start pulse -> alu_op sequence ADD,PASS,ADD; done 4 cycles after the start edge; product=15, prod_zero=0.
- Zero multiplier: op_a=123, op_b=0 -> no RUN cycles, alu_op stays NULL; done 1 cycle after start; product=0, prod_zero=1.
- Full length with wrap: op_a=32'hFFFF_FFFF, op_b=32'h8000_0001 -> done 33 cycles after start; product=32'h7FFF_FFFF.
- Busy-ignore: second start with op_a=2, op_b=2 during RUN of 3*5 -> ignored; product=15. A start held high through DONE is accepted the cycle after IDLE is re-entered -> product=4.
